fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests, buffers responses in a
// small FIFO for decode, and flushes/drops stale work on a redirect.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int          PTR_W = $clog2(QUEUE_DEPTH);
  localparam int          CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int          CRD_W = $clog2(2 * QUEUE_DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic {BOOT, RUN} state_t;

  state_t             state_reg;
  logic [31:0]        fetch_pc_reg;
  logic [CRD_W-1:0]   outstanding_reg;
  logic [CRD_W-1:0]   drop_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   pc_rd_ptr_reg;
  logic [PTR_W-1:0]   pc_wr_ptr_reg;

  logic [31:0] data_mem     [QUEUE_DEPTH];
  logic [31:0] pc_mem       [QUEUE_DEPTH];
  logic [31:0] inflight_mem [QUEUE_DEPTH];

  logic [CRD_W:0] in_use;
  logic           accept;
  logic           push;
  logic           pop;

  // Live in-flight requests plus buffered words never exceed the FIFO size,
  // so every live response always has a slot waiting for it.
  assign in_use         = (CRD_W+1)'(count_reg) + (CRD_W+1)'(outstanding_reg);
  assign imem_req_valid = (state_reg == RUN) && !redirect_valid &&
                          (in_use < (CRD_W+1)'(QUEUE_DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (drop_reg == '0) && !redirect_valid;
  assign instr_valid    = (count_reg != '0);
  assign pop            = instr_valid && instr_ready;
  assign instr          = instr_valid ? data_mem[rd_ptr_reg] : NOP;
  assign instr_pc       = instr_valid ? pc_mem[rd_ptr_reg] : 32'h0000_0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= BOOT;
      fetch_pc_reg    <= RESET_PC & ~32'h3;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      pc_rd_ptr_reg   <= '0;
      pc_wr_ptr_reg   <= '0;
    end else begin
      state_reg <= RUN;
      if (redirect_valid) begin
        // Everything still in flight becomes stale; an arriving response is one of them.
        fetch_pc_reg    <= redirect_pc & ~32'h3;
        drop_reg        <= drop_reg + outstanding_reg - CRD_W'(imem_rsp_valid);
        outstanding_reg <= '0;
        count_reg       <= '0;
        rd_ptr_reg      <= '0;
        wr_ptr_reg      <= '0;
        pc_rd_ptr_reg   <= '0;
        pc_wr_ptr_reg   <= '0;
      end else begin
        if (accept) begin
          fetch_pc_reg  <= fetch_pc_reg + 32'd4;
          pc_wr_ptr_reg <= pc_wr_ptr_reg + PTR_W'(1);
        end
        if (imem_rsp_valid && (drop_reg != '0)) begin
          drop_reg <= drop_reg - CRD_W'(1);
        end
        if (push) begin
          wr_ptr_reg    <= wr_ptr_reg + PTR_W'(1);
          pc_rd_ptr_reg <= pc_rd_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
        outstanding_reg <= outstanding_reg + CRD_W'(accept) - CRD_W'(push);
        count_reg       <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (accept) begin
      inflight_mem[pc_wr_ptr_reg] <= fetch_pc_reg;
    end
    if (push) begin
      data_mem[wr_ptr_reg] <= imem_rsp_data;
      pc_mem[wr_ptr_reg]   <= inflight_mem[pc_rd_ptr_reg];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an epoch-tagged memory/decode model predicts
// every output each cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int          D   = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  typedef struct {logic [31:0] addr; int epoch; int due;} req_t;
  typedef struct {logic [31:0] data; logic [31:0] pc;} ent_t;

  req_t        memq[$];
  ent_t        fifo_m[$];
  logic [31:0] m_fetch;
  int          epoch = 0, run_cycles = 0, cyc = 0;
  int          n_checks = 0, n_errors = 0;

  int          p_ready = 100, p_iready = 100, p_redir = 0, lat_min = 1, lat_max = 1;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc = 32'h0;

  bit          obs_acc, obs_ivalid, obs_reqv;
  logic [31:0] obs_acc_addr, obs_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out, got no event expected one (cycle %0d)", name, cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"},   imem_req_valid, 1'b0);
    chk({tag, "_req_addr"},    imem_req_addr,  32'h0);
    chk({tag, "_instr_valid"}, instr_valid,    1'b0);
    chk({tag, "_instr"},       instr,          NOP);
    chk({tag, "_instr_pc"},    instr_pc,       32'h0);
  endtask

  task automatic model_reset();
    memq.delete();
    fifo_m.delete();
    m_fetch    = 32'h0;
    epoch++;
    run_cycles = 0;
  endtask

  // One clock cycle: entered and left just after a rising edge.
  task automatic step();
    int   live, lat;
    bit   exp_rv, exp_iv, acc, pop;
    req_t h;
    imem_req_ready = ($urandom_range(99) < p_ready);
    instr_ready    = ($urandom_range(99) < p_iready);
    redirect_valid = force_redir || ($urandom_range(99) < p_redir);
    if (force_redir) redirect_pc = force_pc;
    else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF8 | 32'($urandom_range(7));
    else redirect_pc = $urandom;
    force_redir = 1'b0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    live = 0;
    foreach (memq[i]) if (memq[i].epoch == epoch) live++;
    exp_rv = (run_cycles >= 1) && !redirect_valid && (fifo_m.size() + live < D);
    exp_iv = (fifo_m.size() > 0);
    chk("req_valid",   imem_req_valid, exp_rv);
    chk("req_addr",    imem_req_addr,  m_fetch);
    chk("instr_valid", instr_valid,    exp_iv);
    chk("instr",       instr,          exp_iv ? fifo_m[0].data : NOP);
    if (exp_iv) chk("instr_pc", instr_pc, fifo_m[0].pc);
    acc          = exp_rv && imem_req_ready;
    pop          = exp_iv && instr_ready;
    obs_acc      = acc;
    obs_acc_addr = m_fetch;
    obs_ivalid   = instr_valid;
    obs_ipc      = instr_pc;
    obs_reqv     = imem_req_valid;
    if (pop) void'(fifo_m.pop_front());
    if (imem_rsp_valid) begin
      h = memq.pop_front();
      if (!redirect_valid && h.epoch == epoch) fifo_m.push_back('{mem_word(h.addr), h.addr});
    end
    if (acc) begin
      lat = int'($urandom_range(lat_max, lat_min));
      memq.push_back('{m_fetch, epoch, cyc + lat});
      m_fetch += 32'd4;
    end
    if (redirect_valid) begin
      epoch++;
      fifo_m.delete();
      m_fetch = redirect_pc & ~32'h3;
    end
    run_cycles++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_acc, first_iv, n;
    logic [31:0] first_addr, first_pc;
    logic [31:0] addrs [2];
    bit          found;
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("phase: boot and straight-line fetch");
    first_acc = -1; first_iv = -1; first_addr = 32'hX; first_pc = 32'hX;
    for (int k = 0; k < 12; k++) begin
      step();
      if (obs_acc && first_acc < 0) begin first_acc = k; first_addr = obs_acc_addr; end
      if (obs_ivalid && first_iv < 0) begin first_iv = k; first_pc = obs_ipc; end
    end
    chk("first_req_cycle", first_acc, 1);
    chk("first_req_addr", first_addr, 32'h0);
    chk("first_valid_latency", first_iv - first_acc, 2);
    chk("first_instr_pc", first_pc, 32'h0);

    $display("phase: decode stall fills queue");
    p_iready = 0;
    repeat (8) step();
    chk("stall_req_valid", obs_reqv, 1'b0);
    chk("stall_instr_valid", obs_ivalid, 1'b1);
    p_iready = 100;
    repeat (8) step();

    $display("phase: memory stall with redirect to 0x100");
    p_ready = 0;
    step();
    force_redir = 1'b1; force_pc = 32'h0000_0100;
    step();
    step();
    p_ready = 100;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (obs_acc) begin chk("redirect_addr", obs_acc_addr, 32'h0000_0100); found = 1'b1; end
    end
    if (!found) timeout("redirect_addr");

    $display("phase: redirect to 0x203 with requests in flight");
    lat_min = 3; lat_max = 3;
    repeat (6) step();
    force_redir = 1'b1; force_pc = 32'h0000_0203;
    step();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (obs_ivalid) begin chk("redirect_first_pc", obs_ipc, 32'h0000_0200); found = 1'b1; end
    end
    if (!found) timeout("redirect_first_pc");

    $display("phase: address wrap");
    lat_min = 1; lat_max = 1;
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
    step();
    n = 0;
    for (int k = 0; k < 20 && n < 2; k++) begin
      step();
      if (obs_acc) begin addrs[n] = obs_acc_addr; n++; end
    end
    if (n < 2) timeout("wrap_addrs");
    else begin
      chk("wrap_addr0", addrs[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", addrs[1], 32'h0000_0000);
    end

    $display("phase: randomized traffic");
    p_ready = 70; p_iready = 60; p_redir = 6; lat_min = 1; lat_max = 4;
    repeat (3000) step();

    $display("phase: asynchronous reset mid-stream");
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (300) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
